// File: rtl/aes_key_schedule_if.sv
// Key-load / round-key read bundle between the AES key schedule and its consumers.
// Handshake: a key transfers on a rising edge where key_valid && key_ready; key_valid
// while key_ready is low is ignored (never queued), and rk_out is a same-cycle read of rd_idx.
interface aes_key_schedule_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rk_out;
  logic         keys_ready;
  logic [1:0]   state_dbg;

  modport slave (
    input  key_in, key_valid, rd_idx,
    output key_ready, rk_out, keys_ready, state_dbg
  );

  modport master (
    output key_in, key_valid, rd_idx,
    input  key_ready, rk_out, keys_ready, state_dbg
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion: one round key per clock into an 11-entry buffer
// with a combinational read port. Optional synchronous wipe via macro AES_KS_ZEROIZE_EN.
module aes_key_schedule #(
  parameter int           NR        = 10,
  parameter logic [127:0] OOR_VALUE = 128'h0
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic zeroize,
`endif
  aes_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         keys_ready_q, keys_ready_d;
  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];

  logic         key_ready_c;
  logic         accept;
  logic [127:0] prev_rk;
  logic [127:0] next_rk;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [127:0] rk_out_c;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign key_ready_c = (state_q != EXPAND);
  assign accept      = bus.key_valid & key_ready_c;

  // Round step: the previous round key is the entry just below the one being written.
  always_comb begin
    prev_rk = rk_q[0];
    for (int i = 1; i <= NR; i++) begin
      if (cnt_q == 4'(i)) prev_rk = rk_q[i-1];
    end
    rot_w      = {prev_rk[23:0], prev_rk[31:24]};
    sub_w      = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    sub_w      = sub_w ^ {rcon_q, 24'h0};
    next_rk[127:96] = prev_rk[127:96] ^ sub_w;
    next_rk[95:64]  = prev_rk[95:64]  ^ next_rk[127:96];
    next_rk[63:32]  = prev_rk[63:32]  ^ next_rk[95:64];
    next_rk[31:0]   = prev_rk[31:0]   ^ next_rk[63:32];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcon_d       = rcon_q;
    keys_ready_d = keys_ready_q;
    rk_d         = rk_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          rk_d[0]      = bus.key_in;
          cnt_d        = 4'd1;
          rcon_d       = 8'h01;
          keys_ready_d = 1'b0;
          state_d      = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (cnt_q == 4'(i)) rk_d[i] = next_rk;
        end
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          keys_ready_d = 1'b1;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_KS_ZEROIZE_EN
    // Wipe wins over everything, including a key offered on the same edge.
    if (zeroize) begin
      rk_d         = '{default: '0};
      keys_ready_d = 1'b0;
      cnt_d        = 4'd0;
      rcon_d       = 8'h01;
      state_d      = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      rcon_q       <= 8'h01;
      keys_ready_q <= 1'b0;
      rk_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcon_q       <= rcon_d;
      keys_ready_q <= keys_ready_d;
      rk_q         <= rk_d;
    end
  end

  always_comb begin
    rk_out_c = OOR_VALUE;
    for (int i = 0; i <= NR; i++) begin
      if (bus.rd_idx == 4'(i)) rk_out_c = rk_q[i];
    end
  end

  assign bus.rk_out     = rk_out_c;
  assign bus.key_ready  = key_ready_c;
  assign bus.keys_ready = keys_ready_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: a driver issues keys, a monitor sweeps the
// round-key buffer whenever keys_ready rises and compares against a FIPS-197 model.
`timescale 1ns/10ps
module tb_aes_key_schedule;

  logic clk;
  logic rst_n;
`ifdef AES_KS_ZEROIZE_EN
  logic zeroize;
`endif

  aes_key_schedule_if bus ();

  aes_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize (zeroize),
`endif
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got time %0t required < 400000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int           acc_cyc_q[$];
  int           kat_n_q[$];
  int           kat_idx_q[$];
  logic [127:0] kat_val_q[$];
  int           pend_kat = 0;
  int           sweep_req = 0;
  int           sweep_ack = 0;
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [7:0]   sb_tab [0:255];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %032h required %032h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, x8;
    for (int x = 0; x < 256; x++) begin
      x8  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expected(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  task automatic add_kat(input int idx, input logic [127:0] val);
    kat_idx_q.push_back(idx);
    kat_val_q.push_back(val);
    pend_kat++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_accept(input logic [127:0] k);
    @(negedge clk);
    check("key_ready_before_accept", {127'b0, bus.key_ready}, 128'd1);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    push_expected(k);
    kat_n_q.push_back(pend_kat);
    pend_kat = 0;
    @(posedge clk);
    #1;
    acc_cyc_q.push_back(cyc);
    check("keys_ready_falls_on_accept", {127'b0, bus.keys_ready}, 128'd0);
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("key_ready_busy_n1", {127'b0, bus.key_ready}, 128'd0);
  endtask

  task automatic do_abort();
    rst_n = 1'b0;
    #1;
    check("abort_keys_ready", {127'b0, bus.keys_ready}, 128'd0);
    check("abort_key_ready", {127'b0, bus.key_ready}, 128'd1);
    check("abort_rk_out", bus.rk_out, 128'd0);
    check("abort_state", {126'b0, bus.state_dbg}, 128'd0);
    exp_q.delete(); acc_cyc_q.delete(); kat_n_q.delete();
    kat_idx_q.delete(); kat_val_q.delete(); pend_kat = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // pulse_at / abort_at name the negedge (2..10) after the accept edge; 0 means none.
  task automatic do_txn(input logic [127:0] k, input int pulse_at, input int abort_at);
    bit seen;
    do_accept(k);
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (abort_at == n) begin
        bus.key_valid = 1'b0;
        do_abort();
        return;
      end
      check("key_ready_busy", {127'b0, bus.key_ready}, 128'd0);
      if (pulse_at == n) begin
        bus.key_in    = {$urandom, $urandom, $urandom, $urandom};
        bus.key_valid = 1'b1;
      end else begin
        bus.key_valid = 1'b0;
      end
    end
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus.keys_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL keys_ready_timeout: got 0 required 1 within 20 cycles");
    end
  endtask

  // ---------------- monitor ----------------
  logic kr_prev = 1'b0;
  initial begin
    bus.rd_idx = 4'd0;
    forever begin
      @(negedge clk);
      if ((bus.keys_ready && !kr_prev) || (sweep_req != sweep_ack)) begin
        if (bus.keys_ready && !kr_prev) begin
          if (acc_cyc_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL latency: got keys_ready with no accept outstanding");
          end else begin
            check("latency", 128'(cyc - acc_cyc_q.pop_front()), 128'd10);
          end
        end else begin
          sweep_ack++;
        end
        if (exp_q.size() < 11) begin
          n_cmp++; n_fail++;
          $display("FAIL exp_underflow: got %0d entries required 11", exp_q.size());
        end else begin
          for (int i = 0; i < 11; i++) begin
            bus.rd_idx = 4'(i);
            #0.1;
            check($sformatf("rk%0d", i), bus.rk_out, exp_q.pop_front());
          end
          if (kat_n_q.size() > 0) begin
            int n;
            n = kat_n_q.pop_front();
            for (int j = 0; j < n; j++) begin
              bus.rd_idx = 4'(kat_idx_q[0]);
              #0.1;
              check($sformatf("kat_rk%0d", kat_idx_q.pop_front()), bus.rk_out, kat_val_q.pop_front());
            end
          end
          for (int i = 11; i < 16; i++) begin
            bus.rd_idx = 4'(i);
            #0.1;
            check($sformatf("oor_idx%0d", i), bus.rk_out, 128'h0);
          end
        end
        bus.rd_idx = 4'd0;
      end
      kr_prev = bus.keys_ready;
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    rst_n         = 1'b0;
    bus.key_in    = '0;
    bus.key_valid = 1'b0;
`ifdef AES_KS_ZEROIZE_EN
    zeroize       = 1'b0;
`endif
    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_key_ready", {127'b0, bus.key_ready}, 128'd1);
    check("reset_keys_ready", {127'b0, bus.keys_ready}, 128'd0);
    check("reset_rk_out", bus.rk_out, 128'd0);
    check("reset_state", {126'b0, bus.state_dbg}, 128'd0);
    rst_n = 1'b1;

    add_kat(1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    add_kat(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    do_txn(K1, 5, 0);

    add_kat(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    add_kat(0,  K2);
    do_txn(K2, 0, 0);

    do_txn(K1, 3, 5);
    add_kat(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    do_txn(K1, 0, 0);

`ifdef AES_KS_ZEROIZE_EN
    @(negedge clk);
    zeroize = 1'b1;
    @(posedge clk);
    #1;
    check("zeroize_keys_ready", {127'b0, bus.keys_ready}, 128'd0);
    check("zeroize_state", {126'b0, bus.state_dbg}, 128'd0);
    @(negedge clk);
    zeroize = 1'b0;
    for (int i = 0; i < 11; i++) exp_q.push_back(128'h0);
    kat_n_q.push_back(0);
    sweep_req++;
    repeat (3) @(negedge clk);
    zeroize       = 1'b1;
    bus.key_in    = {$urandom, $urandom, $urandom, $urandom};
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    check("zeroize_vs_accept_state", {126'b0, bus.state_dbg}, 128'd0);
    @(negedge clk);
    zeroize       = 1'b0;
    bus.key_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("zeroize_dropped_key", {127'b0, bus.keys_ready}, 128'd0);
`endif

    for (int it = 0; it < 10; it++) begin
      int gap, pulse, abort_n;
      gap     = $urandom_range(0, 3);
      pulse   = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : 0;
      abort_n = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 10) : 0;
      repeat (gap) @(negedge clk);
      do_txn({$urandom, $urandom, $urandom, $urandom}, pulse, abort_n);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
